// File: rtl/banco_pesos.sv
// Weight holder beside epoca. It stores w0..w2, drives them onto the shared w-bus while the
// trainer reads, and captures the trainer's results at each epoch end to sequence training.
module banco_pesos #(
    parameter int             TAM        = 16,
    parameter int             MAX_EPOCAS = 32,
    parameter logic [TAM-1:0] W_INIT     = 16'h0000
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic           direction,
    inout  wire  [TAM-1:0] w0,
    inout  wire  [TAM-1:0] w1,
    inout  wire  [TAM-1:0] w2,
    input  logic [TAM-1:0] w0_out,
    input  logic [TAM-1:0] w1_out,
    input  logic [TAM-1:0] w2_out,
    output logic           treino_reset,
    output logic [TAM-1:0] w0_q,
    output logic [TAM-1:0] w1_q,
    output logic [TAM-1:0] w2_q,
    output logic [7:0]     epoca_cnt,
    output logic           busy,
    output logic           done,
    output logic           convergiu
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RESET_T  = 3'd1,
        RUN      = 3'd2,
        WAIT_LOW = 3'd3,
        DONE     = 3'd4
    } state_t;

    localparam int         LIMIT   = (MAX_EPOCAS > 255) ? 255 : MAX_EPOCAS;
    localparam logic [7:0] LIMIT_C = 8'(LIMIT);

    // Bitwise equality, except that +0 and -0 are treated as the same weight.
    function automatic logic peso_igual(input logic [TAM-1:0] a, input logic [TAM-1:0] b);
        logic zeros;
        zeros = (a[TAM-2:0] == {(TAM-1){1'b0}}) && (b[TAM-2:0] == {(TAM-1){1'b0}});
        return (a == b) || zeros;
    endfunction

    state_t         state_q, state_d;
    logic [TAM-1:0] w0_d, w1_d, w2_d;
    logic [7:0]     cnt_q, cnt_d, cnt_inc_s;
    logic           conv_q, conv_d;
    logic           treino_q, treino_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           dir_s, same_s, drive_s;

    // Next-state, capture and registered-output computation.
    always_comb begin
        state_d = state_q;
        w0_d    = w0_q;
        w1_d    = w1_q;
        w2_d    = w2_q;
        cnt_d   = cnt_q;
        conv_d  = conv_q;
        // An unknown direction falls into the else branch and behaves as a read.
        if (direction) begin
            dir_s = 1'b1;
        end else begin
            dir_s = 1'b0;
        end
        cnt_inc_s = (cnt_q == 8'd255) ? 8'd255 : cnt_q + 8'd1;
        same_s    = peso_igual(w0_out, w0_q) && peso_igual(w1_out, w1_q)
                    && peso_igual(w2_out, w2_q);
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    w0_d    = W_INIT;
                    w1_d    = W_INIT;
                    w2_d    = W_INIT;
                    cnt_d   = 8'd0;
                    conv_d  = 1'b0;
                    state_d = RESET_T;
                end else begin
                    state_d = state_q;
                end
            end
            RESET_T: state_d = RUN;
            RUN: begin
                if (dir_s) begin
                    w0_d  = w0_out;
                    w1_d  = w1_out;
                    w2_d  = w2_out;
                    cnt_d = cnt_inc_s;
                    if (same_s) begin
                        conv_d  = 1'b1;
                        state_d = DONE;
                    end else if (cnt_inc_s == LIMIT_C) begin
                        conv_d  = 1'b0;
                        state_d = DONE;
                    end else begin
                        state_d = WAIT_LOW;
                    end
                end else begin
                    state_d = RUN;
                end
            end
            WAIT_LOW: begin
                if (!dir_s) begin
                    state_d = RESET_T;
                end else begin
                    state_d = WAIT_LOW;
                end
            end
            default: state_d = IDLE;
        endcase
        treino_d = (state_d != RUN) && (state_d != WAIT_LOW);
        busy_d   = (state_d == RESET_T) || (state_d == RUN) || (state_d == WAIT_LOW);
        done_d   = (state_d == DONE);
    end

    // State, weight and status registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            w0_q     <= W_INIT;
            w1_q     <= W_INIT;
            w2_q     <= W_INIT;
            cnt_q    <= 8'd0;
            conv_q   <= 1'b0;
            treino_q <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            w0_q     <= w0_d;
            w1_q     <= w1_d;
            w2_q     <= w2_d;
            cnt_q    <= cnt_d;
            conv_q   <= conv_d;
            treino_q <= treino_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    // The bus follows state_q combinationally so an async reset releases it at once.
    assign drive_s = !dir_s && (state_q != IDLE);
    assign w0 = drive_s ? w0_q : {TAM{1'bz}};
    assign w1 = drive_s ? w1_q : {TAM{1'bz}};
    assign w2 = drive_s ? w2_q : {TAM{1'bz}};

    assign treino_reset = treino_q;
    assign epoca_cnt    = cnt_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign convergiu    = conv_q;

endmodule

// File: tb/tb_banco_pesos.sv
// Directed bench for banco_pesos: one instance with the default epoch limit, one with limit 3.
// Bus lines are pulled up, so a released bus reads as all ones.
module tb_banco_pesos;

    logic        clk = 1'b0;
    logic        reset;
    logic        start1, dir1, start2, dir2;
    logic [15:0] wo1, wo2;
    wire  [15:0] a0, a1, a2, b0, b1, b2;
    logic        tr1, busy1, done1, conv1, tr2, busy2, done2, conv2;
    logic [15:0] q10, q11, q12, q20, q21, q22;
    logic [7:0]  cnt1, cnt2;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    for (genvar i = 0; i < 16; i++) begin : g_pu
        pullup pa0 (a0[i]);
        pullup pa1 (a1[i]);
        pullup pa2 (a2[i]);
        pullup pb0 (b0[i]);
        pullup pb1 (b1[i]);
        pullup pb2 (b2[i]);
    end

    banco_pesos u1 (
        .clk(clk), .reset(reset), .start(start1), .direction(dir1),
        .w0(a0), .w1(a1), .w2(a2), .w0_out(wo1), .w1_out(wo1), .w2_out(wo1),
        .treino_reset(tr1), .w0_q(q10), .w1_q(q11), .w2_q(q12), .epoca_cnt(cnt1),
        .busy(busy1), .done(done1), .convergiu(conv1)
    );

    banco_pesos #(.MAX_EPOCAS(3)) u2 (
        .clk(clk), .reset(reset), .start(start2), .direction(dir2),
        .w0(b0), .w1(b1), .w2(b2), .w0_out(wo2), .w1_out(wo2), .w2_out(wo2),
        .treino_reset(tr2), .w0_q(q20), .w1_q(q21), .w2_q(q22), .epoca_cnt(cnt2),
        .busy(busy2), .done(done2), .convergiu(conv2)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (5) step();
        checks++; if (a0 !== 16'hFFFF) begin failures++; $display("FAIL rst_bus got=%h exp=ffff", a0); end
        checks++; if (tr1 !== 1'b1) begin failures++; $display("FAIL rst_treino got=%b exp=1", tr1); end
        checks++; if (q10 !== 16'h0000 || q12 !== 16'h0000) begin failures++; $display("FAIL rst_w got=%h/%h exp=0000", q10, q12); end
        checks++; if (done1 !== 1'b0 || busy1 !== 1'b0) begin failures++; $display("FAIL rst_flags got=%b%b exp=00", done1, busy1); end
        checks++; if (cnt1 !== 8'd0 || cnt2 !== 8'd0) begin failures++; $display("FAIL rst_cnt got=%0d/%0d exp=0", cnt1, cnt2); end
    endtask

    task automatic test_first_epoch();
        start1 = 1'b1; step(); start1 = 1'b0;
        checks++; if (tr1 !== 1'b1 || busy1 !== 1'b1) begin failures++; $display("FAIL rt_state got=%b%b exp=11", tr1, busy1); end
        checks++; if (a0 !== 16'h0000) begin failures++; $display("FAIL rt_bus got=%h exp=0000", a0); end
        step();
        checks++; if (tr1 !== 1'b0) begin failures++; $display("FAIL run_treino got=%b exp=0", tr1); end
        step();
        wo1 = 16'h3800; dir1 = 1'b1; step();
        checks++; if (q10 !== 16'h3800 || q12 !== 16'h3800) begin failures++; $display("FAIL ep1_w got=%h/%h exp=3800", q10, q12); end
        checks++; if (cnt1 !== 8'd1 || done1 !== 1'b0) begin failures++; $display("FAIL ep1_cnt got=%0d done=%b exp=1 0", cnt1, done1); end
        checks++; if (a0 !== 16'hFFFF) begin failures++; $display("FAIL ep1_release got=%h exp=ffff", a0); end
        dir1 = 1'b0; #1;
        checks++; if (a1 !== 16'h3800) begin failures++; $display("FAIL ep1_bus got=%h exp=3800", a1); end
        step();
        checks++; if (tr1 !== 1'b1) begin failures++; $display("FAIL ep2_rt got=%b exp=1", tr1); end
        step();
        checks++; if (tr1 !== 1'b0) begin failures++; $display("FAIL ep2_run got=%b exp=0", tr1); end
    endtask

    task automatic test_converge();
        dir1 = 1'b1; step();
        checks++; if (done1 !== 1'b1 || conv1 !== 1'b1) begin failures++; $display("FAIL conv_flags got=%b%b exp=11", done1, conv1); end
        checks++; if (cnt1 !== 8'd2 || busy1 !== 1'b0 || tr1 !== 1'b1) begin failures++; $display("FAIL conv_cnt got=%0d busy=%b tr=%b exp=2 0 1", cnt1, busy1, tr1); end
        dir1 = 1'b0;
    endtask

    task automatic test_limit();
        start2 = 1'b1; step(); start2 = 1'b0; step();
        for (int k = 1; k <= 3; k++) begin
            wo2 = 16'(k); dir2 = 1'b1; step();
            if (k < 3) begin
                checks++; if (cnt2 !== 8'(k) || done2 !== 1'b0) begin failures++; $display("FAIL lim_ep%0d got=%0d done=%b exp=%0d 0", k, cnt2, done2, k); end
                dir2 = 1'b0; step(); step();
            end
        end
        checks++; if (done2 !== 1'b1 || conv2 !== 1'b0) begin failures++; $display("FAIL lim_flags got=%b%b exp=10", done2, conv2); end
        checks++; if (cnt2 !== 8'd3 || q21 !== 16'h0003) begin failures++; $display("FAIL lim_cnt got=%0d w=%h exp=3 0003", cnt2, q21); end
        dir2 = 1'b0;
    endtask

    task automatic test_hold_dir();
        start1 = 1'b1; step(); start1 = 1'b0; step();
        start1 = 1'b1; step(); start1 = 1'b0;
        checks++; if (busy1 !== 1'b1 || tr1 !== 1'b0 || cnt1 !== 8'd0) begin failures++; $display("FAIL busy_start got=%b%b cnt=%0d exp=10 0", busy1, tr1, cnt1); end
        wo1 = 16'h3800; dir1 = 1'b1; step();
        wo1 = 16'h1234; repeat (3) step();
        checks++; if (q10 !== 16'h3800 || cnt1 !== 8'd1 || done1 !== 1'b0) begin failures++; $display("FAIL hold got=%h cnt=%0d done=%b exp=3800 1 0", q10, cnt1, done1); end
        dir1 = 1'b0; step(); step();
        wo1 = 16'h8000; dir1 = 1'b1; step();
        checks++; if (q11 !== 16'h8000 || cnt1 !== 8'd2 || done1 !== 1'b0) begin failures++; $display("FAIL neg0 got=%h cnt=%0d done=%b exp=8000 2 0", q11, cnt1, done1); end
        dir1 = 1'b0; step(); step();
        wo1 = 16'h0000; dir1 = 1'b1; step();
        checks++; if (done1 !== 1'b1 || conv1 !== 1'b1 || cnt1 !== 8'd3) begin failures++; $display("FAIL pm0 got=%b%b cnt=%0d exp=11 3", done1, conv1, cnt1); end
        dir1 = 1'b0;
    endtask

    task automatic test_reset_mid();
        start1 = 1'b1; step(); start1 = 1'b0; step(); step();
        checks++; if (a0 !== 16'h0000) begin failures++; $display("FAIL mid_driven got=%h exp=0000", a0); end
        wo1 = 16'h5555; dir1 = 1'b1; #2; reset = 1'b1; #1;
        checks++; if (a0 !== 16'hFFFF || q10 !== 16'h0000) begin failures++; $display("FAIL mid_rst got=%h w=%h exp=ffff 0000", a0, q10); end
        checks++; if (busy1 !== 1'b0 || done1 !== 1'b0 || tr1 !== 1'b1 || cnt1 !== 8'd0) begin failures++; $display("FAIL mid_flags got=%b%b%b cnt=%0d exp=001 0", busy1, done1, tr1, cnt1); end
        step(); reset = 1'b0; dir1 = 1'b0; step();
    endtask

    task automatic test_start_vs_dir();
        start1 = 1'b1; dir1 = 1'b1; wo1 = 16'h7777; step(); start1 = 1'b0;
        checks++; if (cnt1 !== 8'd0 || q10 !== 16'h0000) begin failures++; $display("FAIL sd_nocap got=%0d w=%h exp=0 0000", cnt1, q10); end
        checks++; if (busy1 !== 1'b1 || tr1 !== 1'b1) begin failures++; $display("FAIL sd_start got=%b%b exp=11", busy1, tr1); end
        dir1 = 1'b0;
    endtask

    initial begin
        reset = 1'b1; start1 = 1'b0; dir1 = 1'b0; start2 = 1'b0; dir2 = 1'b0;
        wo1 = 16'h0000; wo2 = 16'h0000;
        repeat (3) step();
        reset = 1'b0;
        test_reset();
        test_first_epoch();
        test_converge();
        test_limit();
        test_hold_dir();
        test_reset_mid();
        test_start_vs_dir();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
